// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: default count width, FSM states
// and the saturation limit helper.
package period_meter_pkg;

  // Matches the clock divider's toggle_value width.
  localparam int PM_W_DEFAULT = 22;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_OVF     = 2'd2
  } state_e;

  // All-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Two-flop synchronizer plus one delay flop; flags either transition of an
// asynchronous input as a single-cycle pulse.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic edge_o
);

  logic s1_q, s2_q, s3_q;

  // NOTE: non-blocking assignments make s1->s2->s3 a true shift register;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures the half-period of an asynchronous square wave in clk_in cycles,
// reported in divider toggle_value encoding (cycles between edges minus one).
module period_meter
  import period_meter_pkg::*;
#(
  parameter int W   = PM_W_DEFAULT,
  parameter int TOL = 0
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] half_period,
  output logic         meas_valid,
  output logic         locked,
  output logic         overflow
);

  localparam logic [W-1:0] CNT_MAX = W'(cnt_max(W));
  localparam logic [W:0]   TOL_V   = (W+1)'(TOL);

  logic         sig_edge;
  state_e       state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] half_period_q;
  logic         meas_valid_q;
  logic         locked_q;
  logic         overflow_q;
  logic         have_prev_q;
  logic [W:0]   diff;
  logic         within_tol;

  sync_edge_detect u_sync (
    .clk_i  (clk_in),
    .rst_ni (rst),
    .sig_i  (sig_in),
    .edge_o (sig_edge)
  );

  // Distance from the previous result, one bit wider so it can never wrap.
  always_comb begin
    diff = '0;
    if (cnt_q >= half_period_q) begin
      diff = {1'b0, cnt_q} - {1'b0, half_period_q};
    end else begin
      diff = {1'b0, half_period_q} - {1'b0, cnt_q};
    end
    within_tol = (diff <= TOL_V);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      half_period_q <= '0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      overflow_q    <= 1'b0;
      have_prev_q   <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (sig_edge) begin
            state_q     <= ST_MEASURE;
            cnt_q       <= '0;
            have_prev_q <= 1'b0;
          end
        end
        ST_MEASURE: begin
          // An edge wins over saturation, so a full-scale interval still reports.
          if (sig_edge) begin
            half_period_q <= cnt_q;
            meas_valid_q  <= 1'b1;
            cnt_q         <= '0;
            locked_q      <= have_prev_q && within_tol;
            have_prev_q   <= 1'b1;
            overflow_q    <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            state_q    <= ST_OVF;
            overflow_q <= 1'b1;
            locked_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + W'(1);
          end
        end
        ST_OVF: begin
          // The edge ending an overflowed interval only restarts timing.
          if (sig_edge) begin
            state_q     <= ST_MEASURE;
            cnt_q       <= '0;
            have_prev_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign half_period = half_period_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed scoreboard bench for period_meter: three builds (W=22/TOL=0,
// W=22/TOL=2, W=4/TOL=0) checked against expected results queued at stimulus time.
module tb_period_meter;

  typedef struct {
    logic [31:0] hp;
    logic        lk;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig_in = 1'b0;
  logic        sig_w4 = 1'b0;

  logic [21:0] hp_m, hp_t;
  logic [3:0]  hp_w;
  logic        meas_m, meas_t, meas_w;
  logic        locked_m, locked_t, locked_w;
  logic        ovf_m, ovf_t, ovf_w;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q_m[$];
  exp_t q_t[$];
  exp_t q_w[$];
  exp_t e_m, e_t, e_w;

  always #5 clk = ~clk;

  period_meter #(.W(22), .TOL(0)) u_main (
    .clk_in(clk), .rst(rst), .sig_in(sig_in),
    .half_period(hp_m), .meas_valid(meas_m), .locked(locked_m), .overflow(ovf_m)
  );

  period_meter #(.W(22), .TOL(2)) u_tol2 (
    .clk_in(clk), .rst(rst), .sig_in(sig_in),
    .half_period(hp_t), .meas_valid(meas_t), .locked(locked_t), .overflow(ovf_t)
  );

  period_meter #(.W(4), .TOL(0)) u_w4 (
    .clk_in(clk), .rst(rst), .sig_in(sig_w4),
    .half_period(hp_w), .meas_valid(meas_w), .locked(locked_w), .overflow(ovf_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue the same result for both W=22 builds; only the lock verdict differs.
  task automatic push_22(input int hp, input logic lk_m, input logic lk_t);
    exp_t e;
    e.hp = 32'(hp); e.ov = 1'b0;
    e.lk = lk_m; q_m.push_back(e);
    e.lk = lk_t; q_t.push_back(e);
  endtask

  task automatic push_w4(input int hp, input logic lk);
    exp_t e;
    e.hp = 32'(hp); e.lk = lk; e.ov = 1'b0;
    q_w.push_back(e);
  endtask

  task automatic toggle_after(input int n, input bit w4);
    repeat (n) @(posedge clk);
    #1;
    if (w4) sig_w4 = ~sig_w4;
    else    sig_in = ~sig_in;
  endtask

  task automatic do_reset(input logic sig_val);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    sig_in = sig_val;
    sig_w4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (q_m.size() == 0 && q_t.size() == 0 && q_w.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check(tag, 32'(q_m.size() + q_t.size() + q_w.size()), 32'd0);
  endtask

  // Scoreboard monitors: every meas_valid must match the oldest queued result.
  always @(negedge clk) begin
    if (rst && meas_m) begin
      if (q_m.size() == 0) check("m_spurious_valid", 32'(meas_m), 32'd0);
      else begin
        e_m = q_m.pop_front();
        check("m_half_period", 32'(hp_m), e_m.hp);
        check("m_locked", 32'(locked_m), 32'(e_m.lk));
        check("m_overflow", 32'(ovf_m), 32'(e_m.ov));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && meas_t) begin
      if (q_t.size() == 0) check("t_spurious_valid", 32'(meas_t), 32'd0);
      else begin
        e_t = q_t.pop_front();
        check("t_half_period", 32'(hp_t), e_t.hp);
        check("t_locked", 32'(locked_t), 32'(e_t.lk));
        check("t_overflow", 32'(ovf_t), 32'(e_t.ov));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && meas_w) begin
      if (q_w.size() == 0) check("w_spurious_valid", 32'(meas_w), 32'd0);
      else begin
        e_w = q_w.pop_front();
        check("w_half_period", 32'(hp_w), e_w.hp);
        check("w_locked", 32'(locked_w), 32'(e_w.lk));
        check("w_overflow", 32'(ovf_w), 32'(e_w.ov));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_half_period", 32'(hp_m), 32'd0);
    check("rst_meas_valid", 32'(meas_m), 32'd0);
    check("rst_locked", 32'(locked_m), 32'd0);
    check("rst_overflow", 32'(ovf_m), 32'd0);
    check("rst_w4_half_period", 32'(hp_w), 32'd0);
    rst = 1'b1;

    // Divider-style source, toggle_value 9: edges every 10 cycles.
    toggle_after(3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      toggle_after(10, 1'b0);
      push_22(9, i > 0, i > 0);
    end
    wait_drain("div_drain");
    check("div_overflow", 32'(ovf_m), 32'd0);

    // Asynchronous reset mid-interval while locked.
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_locked", 32'(locked_m), 32'd1);
    #2;
    rst    = 1'b0;
    sig_in = 1'b0;
    #1;
    check("async_rst_half_period", 32'(hp_m), 32'd0);
    check("async_rst_locked", 32'(locked_m), 32'd0);
    check("async_rst_meas_valid", 32'(meas_m), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    toggle_after(3, 1'b0);
    toggle_after(7, 1'b0);
    push_22(6, 1'b0, 1'b0);
    wait_drain("rst_restart_drain");

    // Intervals 10, 10, 12: strict lock drops on 11, TOL=2 lock holds.
    do_reset(1'b0);
    toggle_after(2, 1'b0);
    toggle_after(10, 1'b0); push_22(9, 1'b0, 1'b0);
    toggle_after(10, 1'b0); push_22(9, 1'b1, 1'b1);
    toggle_after(12, 1'b0); push_22(11, 1'b0, 1'b1);
    wait_drain("tol_drain");

    // W=4: full-scale interval, then overflow, silent restart edge, recovery.
    do_reset(1'b0);
    toggle_after(2, 1'b1);
    toggle_after(16, 1'b1); push_w4(15, 1'b0);
    toggle_after(16, 1'b1); push_w4(15, 1'b1);
    repeat (18) @(posedge clk);
    #1;
    check("w_ovf_before_max", 32'(ovf_w), 32'd0);
    check("w_locked_before_ovf", 32'(locked_w), 32'd1);
    @(posedge clk);
    #1;
    check("w_ovf_set", 32'(ovf_w), 32'd1);
    check("w_ovf_locked_cleared", 32'(locked_w), 32'd0);
    toggle_after(1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("w_ovf_held_after_edge", 32'(ovf_w), 32'd1);
    check("w_half_period_held", 32'(hp_w), 32'd15);
    toggle_after(1, 1'b1); push_w4(4, 1'b0);
    wait_drain("w_drain");
    check("w_ovf_cleared", 32'(ovf_w), 32'd0);

    // Edge on every cycle: continuous meas_valid with zero half-period.
    do_reset(1'b0);
    toggle_after(2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      toggle_after(1, 1'b0);
      push_22(0, i > 0, i > 0);
      if (i >= 3) check("cont_meas_valid", 32'(meas_m), 32'd1);
    end
    wait_drain("cont_drain");

    // sig_in high through reset release: its synchronised edge only starts timing.
    do_reset(1'b1);
    toggle_after(8, 1'b0);
    push_22(7, 1'b0, 1'b0);
    wait_drain("high_release_drain");
    check("high_release_locked", 32'(locked_m), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
